// File: rtl/rowhammer_multi_sm.sv
// Row-hammer test sequencer: fills victim and aggressor rows with a pattern, hammers the
// aggressors, then reads the victim row back and counts flipped bits.
module rowhammer_multi_sm #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ROW_WIDTH  = 12,
    parameter int unsigned ROW_POS    = 10,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned COL_POS    = 0,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  double_sided,
    input  logic [1:0]            pattern_mode,
    input  logic [WORD_WIDTH-1:0] pattern,
    input  logic [31:0]           count,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  confirm,
    input  logic [WORD_WIDTH-1:0] pattern_rb,
    output logic                  write,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] gen_address,
    output logic [WORD_WIDTH-1:0] gen_word,
    output logic [CNT_WIDTH-1:0]  bit_flip_count,
    output logic [CNT_WIDTH-1:0]  flip_word_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [3:0]            state
);

    localparam int unsigned POP_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_HAMMER = 4'd2,
        S_CHECK  = 4'd3,
        S_DONE   = 4'd5,
        S_CLEAR  = 4'd7
    } state_t;

    // Row selector used for both the fill order and the hammer side
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_V = 2'd2;

    state_t                state_q, state_n;
    logic                  dbl_q, dbl_n;
    logic [1:0]            mode_q, mode_n;
    logic [WORD_WIDTH-1:0] pat_q, pat_n;
    logic [31:0]           cnt_q, cnt_n;
    logic [31:0]           iter_q, iter_n;
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [1:0]            sel_q, sel_n;
    logic [COL_WIDTH-1:0]  col_q, col_n;

    logic                  write_n, read_n;
    logic [ADDR_WIDTH-1:0] gen_address_n;
    logic [WORD_WIDTH-1:0] gen_word_n;
    logic [CNT_WIDTH-1:0]  bfc_n, fwc_n;
    logic [ADDR_WIDTH-1:0] ffa_n;

    logic [ROW_WIDTH-1:0]  row_v, row_a, row_b, row_sel;
    logic [WORD_WIDTH-1:0] diff;
    logic [POP_WIDTH-1:0]  pop;
    logic [SUM_WIDTH-1:0]  bfc_sum, fwc_sum;

    function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [ROW_WIDTH-1:0]  row,
                                                        input logic [COL_WIDTH-1:0]  col);
        logic [ADDR_WIDTH-1:0] a;
        a = base;
        a[ROW_POS +: ROW_WIDTH] = row;
        a[COL_POS +: COL_WIDTH] = col;
        return a;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] exp_word(input logic [1:0]            mode,
                                                       input logic [WORD_WIDTH-1:0] pat,
                                                       input logic                  victim,
                                                       input logic                  row_lsb,
                                                       input logic                  col_lsb);
        case (mode)
            2'd1:    return (row_lsb ^ col_lsb) ? ~pat : pat;
            2'd2:    return victim ? pat : ~pat;
            default: return pat;
        endcase
    endfunction

    function automatic logic [POP_WIDTH-1:0] popcount(input logic [WORD_WIDTH-1:0] w);
        logic [POP_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WORD_WIDTH); i++) begin
            n = n + POP_WIDTH'(w[i]);
        end
        return n;
    endfunction

    // Aggressor rows wrap modulo 2^ROW_WIDTH through natural truncation
    assign row_v = base_q[ROW_POS +: ROW_WIDTH];
    assign row_a = row_v - ROW_WIDTH'(1);
    assign row_b = row_v + ROW_WIDTH'(1);

    always_comb begin
        case (sel_q)
            SEL_A:   row_sel = row_a;
            SEL_B:   row_sel = row_b;
            default: row_sel = row_v;
        endcase
    end

    assign diff    = pattern_rb ^ exp_word(mode_q, pat_q, 1'b1, row_v[0], col_q[0]);
    assign pop     = popcount(diff);
    assign bfc_sum = {1'b0, bit_flip_count} + SUM_WIDTH'(pop);
    assign fwc_sum = {1'b0, flip_word_count} + SUM_WIDTH'(1);

    assign state = state_q;

    // Next-state and next-output logic
    always_comb begin
        state_n       = state_q;
        dbl_n         = dbl_q;
        mode_n        = mode_q;
        pat_n         = pat_q;
        cnt_n         = cnt_q;
        iter_n        = iter_q;
        base_n        = base_q;
        sel_n         = sel_q;
        col_n         = col_q;
        write_n       = write;
        read_n        = read;
        gen_address_n = gen_address;
        gen_word_n    = gen_word;
        bfc_n         = bit_flip_count;
        fwc_n         = flip_word_count;
        ffa_n         = first_fail_addr;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dbl_n   = double_sided;
                    mode_n  = (pattern_mode == 2'd3) ? 2'd0 : pattern_mode;
                    pat_n   = pattern;
                    cnt_n   = count;
                    base_n  = address;
                    sel_n   = SEL_A;
                    col_n   = '0;
                    iter_n  = '0;
                    bfc_n   = '0;
                    fwc_n   = '0;
                    ffa_n   = '0;
                    state_n = S_CLEAR;
                end
            end

            S_CLEAR: state_n = S_FILL;

            S_FILL: begin
                if (!write) begin
                    write_n       = 1'b1;
                    gen_address_n = make_addr(base_q, row_sel, col_q);
                    gen_word_n    = exp_word(mode_q, pat_q, sel_q == SEL_V, row_sel[0], col_q[0]);
                end else if (confirm) begin
                    write_n = 1'b0;
                    if (col_q != '1) begin
                        col_n = col_q + COL_WIDTH'(1);
                    end else begin
                        col_n = '0;
                        case (sel_q)
                            SEL_A: sel_n = dbl_q ? SEL_B : SEL_V;
                            SEL_B: sel_n = SEL_V;
                            default: begin
                                sel_n   = SEL_A;
                                iter_n  = '0;
                                state_n = (cnt_q == 32'd0) ? S_CHECK : S_HAMMER;
                            end
                        endcase
                    end
                end
            end

            S_HAMMER: begin
                if (!read) begin
                    read_n        = 1'b1;
                    gen_address_n = make_addr(base_q, row_sel, '0);
                end else if (confirm) begin
                    read_n = 1'b0;
                    if (dbl_q && (sel_q == SEL_A)) begin
                        sel_n = SEL_B;
                    end else begin
                        sel_n  = SEL_A;
                        iter_n = iter_q + 32'd1;
                        if (iter_q == cnt_q - 32'd1) begin
                            state_n = S_CHECK;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (!read) begin
                    read_n        = 1'b1;
                    gen_address_n = make_addr(base_q, row_v, col_q);
                end else if (confirm) begin
                    read_n = 1'b0;
                    bfc_n  = bfc_sum[CNT_WIDTH] ? '1 : bfc_sum[CNT_WIDTH-1:0];
                    if (diff != '0) begin
                        fwc_n = fwc_sum[CNT_WIDTH] ? '1 : fwc_sum[CNT_WIDTH-1:0];
                        if (flip_word_count == '0) begin
                            ffa_n = gen_address;
                        end
                    end
                    if (col_q == '1) begin
                        state_n = S_DONE;
                    end else begin
                        col_n = col_q + COL_WIDTH'(1);
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            dbl_q           <= 1'b0;
            mode_q          <= '0;
            pat_q           <= '0;
            cnt_q           <= '0;
            iter_q          <= '0;
            base_q          <= '0;
            sel_q           <= SEL_A;
            col_q           <= '0;
            write           <= 1'b0;
            read            <= 1'b0;
            gen_address     <= '0;
            gen_word        <= '0;
            bit_flip_count  <= '0;
            flip_word_count <= '0;
            first_fail_addr <= '0;
        end else begin
            state_q         <= state_n;
            dbl_q           <= dbl_n;
            mode_q          <= mode_n;
            pat_q           <= pat_n;
            cnt_q           <= cnt_n;
            iter_q          <= iter_n;
            base_q          <= base_n;
            sel_q           <= sel_n;
            col_q           <= col_n;
            write           <= write_n;
            read            <= read_n;
            gen_address     <= gen_address_n;
            gen_word        <= gen_word_n;
            bit_flip_count  <= bfc_n;
            flip_word_count <= fwc_n;
            first_fail_addr <= ffa_n;
        end
    end

endmodule

// File: tb/tb_rowhammer_multi_sm.sv
// Bench for rowhammer_multi_sm: a transaction-level model predicts every request and the
// final flip counters; a randomly delayed responder plays the memory adapter.
module tb_rowhammer_multi_sm;

    localparam int unsigned AW   = 32;
    localparam int unsigned WW   = 32;
    localparam int unsigned RW   = 12;
    localparam int unsigned RP   = 10;
    localparam int unsigned CW   = 2;
    localparam int unsigned CP   = 0;
    localparam int unsigned NW   = 64;
    localparam int          NCOL = 1 << CW;
    localparam int          NROW = 1 << RW;

    logic          clk = 1'b0;
    logic          reset, start, double_sided, confirm;
    logic [1:0]    pattern_mode;
    logic [WW-1:0] pattern, pattern_rb, gen_word;
    logic [31:0]   count;
    logic [AW-1:0] address, gen_address, first_fail_addr;
    logic          write, read;
    logic [NW-1:0] bit_flip_count, flip_word_count;
    logic [3:0]    state;

    rowhammer_multi_sm #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .ROW_WIDTH(RW), .ROW_POS(RP),
        .COL_WIDTH(CW), .COL_POS(CP), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .double_sided(double_sided),
        .pattern_mode(pattern_mode), .pattern(pattern), .count(count), .address(address),
        .confirm(confirm), .pattern_rb(pattern_rb), .write(write), .read(read),
        .gen_address(gen_address), .gen_word(gen_word), .bit_flip_count(bit_flip_count),
        .flip_word_count(flip_word_count), .first_fail_addr(first_fail_addr), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] flip[NCOL];
    logic [63:0] exp_bits, exp_words;
    logic [31:0] exp_ffa;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_addr(input logic [31:0] base, input int row, input int col);
        logic [31:0] row_mask, col_mask;
        row_mask = 32'(NROW - 1) << RP;
        col_mask = 32'(NCOL - 1) << CP;
        return (base & ~row_mask & ~col_mask) | (32'(row) << RP) | (32'(col) << CP);
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] mode, input logic [31:0] pat,
                                               input bit victim, input int row, input int col);
        if (mode == 2'd1) return (((row ^ col) & 1) != 0) ? ~pat : pat;
        if (mode == 2'd2) return victim ? pat : ~pat;
        return pat;
    endfunction

    // Expected request stream and result counters for one test run
    task automatic build_model(input logic [31:0] base, input bit dbl, input logic [1:0] mode,
                               input logic [31:0] pat, input int cnt);
        int   v, ra, rb;
        int   rows[$];
        bit   seen;
        txn_t t;
        exp_q.delete();
        v  = int'(base[RP +: RW]);
        ra = (v + NROW - 1) % NROW;
        rb = (v + 1) % NROW;
        rows.push_back(ra);
        if (dbl) rows.push_back(rb);
        rows.push_back(v);
        foreach (rows[i]) begin
            for (int c = 0; c < NCOL; c++) begin
                t.wr   = 1'b1;
                t.addr = mk_addr(base, rows[i], c);
                t.data = model_word(mode, pat, i == rows.size() - 1, rows[i], c);
                exp_q.push_back(t);
            end
        end
        for (int k = 0; k < cnt; k++) begin
            t.wr = 1'b0; t.addr = mk_addr(base, ra, 0); t.data = $urandom;
            exp_q.push_back(t);
            if (dbl) begin
                t.addr = mk_addr(base, rb, 0); t.data = $urandom;
                exp_q.push_back(t);
            end
        end
        exp_bits = '0; exp_words = '0; exp_ffa = '0; seen = 1'b0;
        for (int c = 0; c < NCOL; c++) begin
            t.wr   = 1'b0;
            t.addr = mk_addr(base, v, c);
            t.data = model_word(mode, pat, 1'b1, v, c) ^ flip[c];
            exp_q.push_back(t);
            exp_bits += 64'($countones(flip[c]));
            if (flip[c] != 32'd0) begin
                exp_words += 64'd1;
                if (!seen) exp_ffa = t.addr;
                seen = 1'b1;
            end
        end
    endtask

    task automatic do_start(input logic [31:0] base, input bit dbl, input logic [1:0] mode,
                            input logic [31:0] pat, input int cnt);
        @(negedge clk);
        address = base; double_sided = dbl; pattern_mode = mode; pattern = pat;
        count = 32'(cnt); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        address = $urandom; double_sided = 1'($urandom); pattern_mode = 2'($urandom);
        pattern = $urandom; count = 32'($urandom_range(0, 9));
        check_eq("clear_state", 64'(state), 64'd7);
        check_eq("clear_bits", bit_flip_count, 64'd0);
        check_eq("clear_words", flip_word_count, 64'd0);
    endtask

    // Responder plus request checker; stops at DONE, on budget expiry, or mid-hammer if asked
    task automatic run_seq(input int budget, input bit abort_hammer, input bit poke_start);
        int          cyc = 0;
        int          dly = 0;
        int          hreads = 0;
        bit          active = 1'b0;
        bit          poked = 1'b0;
        txn_t        cur;
        logic [31:0] cur_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            check_eq("wr_rd_excl", 64'(write & read), 64'd0);
            if (confirm) begin
                confirm = 1'b0;
                check_eq("req_gap", 64'(write | read), 64'd0);
            end else begin
                if (!active && (write || read)) begin
                    check_eq("txn_avail", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() == 0) break;
                    cur = exp_q.pop_front();
                    check_eq("req_kind", 64'(write), 64'(cur.wr));
                    check_eq("req_addr", 64'(gen_address), 64'(cur.addr));
                    if (cur.wr) check_eq("req_data", 64'(gen_word), 64'(cur.data));
                    if (!cur.wr && state == 4'd2) hreads++;
                    cur_addr = gen_address;
                    dly      = $urandom_range(0, 3);
                    active   = 1'b1;
                end
                if (active) begin
                    if (dly == 0) begin
                        check_eq("addr_hold", 64'(gen_address), 64'(cur_addr));
                        check_eq("req_held", 64'(write | read), 64'd1);
                        pattern_rb = cur.wr ? 32'($urandom) : cur.data;
                        confirm    = 1'b1;
                        active     = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
            if (poke_start && !poked && state == 4'd1) begin
                start = 1'b1; address = $urandom; pattern = $urandom; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (abort_hammer && hreads >= 2 && (write || read)) break;
            if (!active && !confirm && state == 4'd5) break;
            if (cyc > budget) begin
                check_eq("timeout", 64'(cyc <= budget), 64'd1);
                break;
            end
        end
    endtask

    task automatic check_results(input string name);
        check_eq({name, ":txn_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({name, ":state"}, 64'(state), 64'd5);
        check_eq({name, ":bits"}, bit_flip_count, exp_bits);
        check_eq({name, ":words"}, flip_word_count, exp_words);
        check_eq({name, ":ffa"}, 64'(first_fail_addr), 64'(exp_ffa));
        repeat (3) @(negedge clk);
        check_eq({name, ":hold"}, 64'(state), 64'd5);
        check_eq({name, ":hold_bits"}, bit_flip_count, exp_bits);
    endtask

    task automatic run_case(input string name, input logic [31:0] base, input bit dbl,
                            input logic [1:0] mode, input logic [31:0] pat, input int cnt,
                            input bit poke);
        build_model(base, dbl, mode, pat, cnt);
        do_start(base, dbl, mode, pat, cnt);
        run_seq(2000, 1'b0, poke);
        check_results(name);
    endtask

    task automatic clear_flips();
        for (int c = 0; c < NCOL; c++) flip[c] = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; confirm = 1'b0; pattern_rb = '0; double_sided = 1'b0;
        pattern_mode = '0; pattern = '0; count = '0; address = '0;
        clear_flips();
        repeat (3) @(negedge clk);
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_write", 64'(write), 64'd0);
        check_eq("rst_read", 64'(read), 64'd0);
        check_eq("rst_addr", 64'(gen_address), 64'd0);
        check_eq("rst_word", 64'(gen_word), 64'd0);
        check_eq("rst_bits", bit_flip_count, 64'd0);
        check_eq("rst_words", flip_word_count, 64'd0);
        check_eq("rst_ffa", 64'(first_fail_addr), 64'd0);
        reset = 1'b0;

        run_case("solid", 32'hA000_1403, 1'b1, 2'd0, 32'hFFFF_FFFF, 3, 1'b0);
        flip[2] = 32'h0000_0081;
        run_case("flip2", 32'hA000_1403, 1'b1, 2'd0, 32'hFFFF_FFFF, 3, 1'b0);
        clear_flips();
        run_case("wrap0", 32'h0000_0002, 1'b0, 2'd2, 32'hA5A5_A5A5, 2, 1'b0);
        run_case("cnt0", 32'h1234_1401, 1'b1, 2'd0, 32'h0F0F_1234, 0, 1'b0);
        for (int c = 0; c < NCOL; c++) flip[c] = 32'd1 << $urandom_range(0, 31);
        run_case("checker", 32'h0000_1400, 1'b1, 2'd1, 32'h3C3C_0FF0, 1, 1'b0);
        clear_flips();
        flip[0] = 32'hFFFF_FFFF; flip[3] = 32'h1;
        run_case("rsvd", 32'h5555_FFFF, 1'b1, 2'd3, 32'h89AB_CDEF, 2, 1'b0);

        // Abort in the middle of hammering with a request outstanding
        clear_flips();
        build_model(32'h0000_2800, 1'b1, 2'd0, 32'hDEAD_BEEF, 5);
        do_start(32'h0000_2800, 1'b1, 2'd0, 32'hDEAD_BEEF, 5);
        run_seq(2000, 1'b1, 1'b0);
        check_eq("pre_rst_state", 64'(state), 64'd2);
        reset = 1'b1; confirm = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_state", 64'(state), 64'd0);
        check_eq("mid_rst_read", 64'(read), 64'd0);
        check_eq("mid_rst_write", 64'(write), 64'd0);
        check_eq("mid_rst_bits", bit_flip_count, 64'd0);
        check_eq("mid_rst_words", flip_word_count, 64'd0);
        reset = 1'b0;
        flip[1] = 32'h0101_0000;
        run_case("rerun", 32'h0000_2800, 1'b1, 2'd0, 32'hDEAD_BEEF, 2, 1'b1);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] base;
            int          row;
            base = $urandom;
            row  = (i == 0) ? 0 : (i == 1) ? NROW - 1 : int'($urandom_range(0, NROW - 1));
            base = mk_addr(base, row, int'($urandom_range(0, NCOL - 1)));
            for (int c = 0; c < NCOL; c++) flip[c] = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'd0;
            run_case("rand", base, 1'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 4)),
                     1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rowhammer_multi_sm.md
Name: rowhammer_multi_sm

Overview:
Parametrised successor to the single-pattern memory test state machine. It fills one victim row and its aggressor rows with a selectable data pattern, then hammers the aggressors (single- or double-sided) a programmable number of times. It then reads back every column of the victim row and accumulates bit flips by popcount. It sits between the host control registers and the memory-port adapter and uses the same level-request / confirm-pulse handshake.

Parameters:
ADDR_WIDTH, 32, address width in bits
WORD_WIDTH, 32, data word width in bits
ROW_WIDTH, 12, row field width
ROW_POS, 10, LSB position of row field in address
COL_WIDTH, 10, column field width; columns per row = 2^COL_WIDTH
COL_POS, 0, LSB position of column field in address
CNT_WIDTH, 64, width of flip counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a test when in IDLE or DONE
double_sided  in  1  1: aggressors row-1 and row+1; 0: row-1 only
pattern_mode  in  2  0 solid, 1 checkerboard, 2 row-stripe, 3 reserved (treated as 0)
pattern  in  WORD_WIDTH  base data pattern
count  in  32  hammer iterations
address  in  ADDR_WIDTH  base address; row field = victim row
confirm  in  1  memory adapter completion pulse
pattern_rb  in  WORD_WIDTH  read data, valid in the confirm cycle of a read
write  out  1  write request, level
read  out  1  read request, level
gen_address  out  ADDR_WIDTH  request address
gen_word  out  WORD_WIDTH  write data
bit_flip_count  out  CNT_WIDTH  total flipped bits
flip_word_count  out  CNT_WIDTH  words with at least one flip
first_fail_addr  out  ADDR_WIDTH  address of the first failing word
state  out  4  current state encoding

Behaviour:
- Reset: state=IDLE(0). write, read, gen_address, gen_word, the counters and first_fail_addr are all 0. Reset mid-operation aborts immediately and drops any request.
- start: latches pattern, count, address, double_sided and pattern_mode. Clears the counters and first_fail_addr, then goes to CLEAR(7) for 1 cycle, then FILL(1). start outside IDLE/DONE is ignored.
- Row arithmetic: aggressor rows are (V-1) and (V+1) mod 2^ROW_WIDTH, so they wrap at the row boundaries.
- gen_address: the latched address with the row field and column field replaced; all other bits are kept.
- Expected word E(row,col):
  - mode 0: pattern for all rows.
  - mode 1: pattern when col[0] XOR row[0] = 0, else ~pattern.
  - mode 2: pattern for the victim row, ~pattern for aggressor rows.
- FILL(1): writes E to every column of each aggressor row, then the victim row. Order is aggressor A, aggressor B (double-sided only), then victim, with columns ascending from 0.
- HAMMER(2): one iteration reads column 0 of A, then column 0 of B (B only if double_sided). Runs count iterations; count=0 skips straight to CHECK. Hammer read data is ignored.
- CHECK(3): reads columns 0..2^COL_WIDTH-1 of the victim row. On each confirm, d = pattern_rb XOR E.
  - bit_flip_count += popcount(d).
  - If d != 0, flip_word_count += 1, and the address is captured into first_fail_addr if this is the first failure.
  - Both counters saturate at all-ones.
- DONE(5): holds the results until the next start or reset.
- Handshake:
  - write/read assert the cycle after entering a request. gen_address and gen_word are stable while the request is high.
  - The request deasserts in the cycle after confirm. The next request asserts no earlier than 1 cycle later, with at least 1 idle cycle between requests.
  - confirm while no request is pending is ignored.
  - write and read are never high together.
- Latency: one request at a time. Wait time per request is unbounded and there is no timeout.

Test Plan:
- COL_WIDTH=2, address row=5, mode 0, pattern=FFFFFFFF, double_sided=1, count=3, no flips:
  - 12 writes (rows 4,6,5 × cols 0-3) and 6 hammer reads (4,6,4,6,4,6).
  - 4 check reads, then DONE.
  - bit_flip_count=0, flip_word_count=0.
- Same setup, pattern_rb of col 2 has bits 0 and 7 flipped:
  - bit_flip_count=2, flip_word_count=1, first_fail_addr has row 5, col 2.
- Row=0, double_sided=0, mode 2, pattern=A5A5A5A5:
  - Aggressor row is 4095 (wrap), written with 5A5A5A5A.
  - Hammer reads hit row 4095 only.
- count=0 -> FILL goes directly to CHECK; no hammer reads are issued.
- Mode 1 with a 1-bit flip in every column -> bit_flip_count=4. Checkerboard expectation is verified per column (col 1 of row 5 expects pattern).
- Reset asserted mid-HAMMER -> the next cycle has state=0, read=0 and counters=0. A following start reruns the test cleanly; a start pulse during FILL is ignored.
